// File: rtl/run_len_if.sv
// Bundle for run_len_detector: sample enable, channel inputs, detect outputs
// and run counters. With RUN_DET_STICKY_EN defined it also carries the
// sticky-clear input and the sticky hit flags.
// CNT_W must equal $clog2(RUN_LEN+1) of the attached detector.
interface run_len_if #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 2
);

  logic                      en;
  logic [CHANNELS-1:0]       w;
  logic [CHANNELS-1:0]       out;
  logic [CHANNELS*CNT_W-1:0] run_cnt;
  logic                      any_out;
`ifdef RUN_DET_STICKY_EN
  logic                      clr;
  logic [CHANNELS-1:0]       sticky;
`endif

  // Producer of the button samples (game side / bench).
  modport master (
    output en,
    output w,
    input  out,
    input  run_cnt,
    input  any_out
`ifdef RUN_DET_STICKY_EN
    ,
    output clr,
    input  sticky
`endif
  );

  // The detector itself.
  modport slave (
    input  en,
    input  w,
    output out,
    output run_cnt,
    output any_out
`ifdef RUN_DET_STICKY_EN
    ,
    input  clr,
    output sticky
`endif
  );

endinterface

// File: rtl/run_len_detector.sv
// Multi-channel consecutive-high detector. Each channel runs its own
// IDLE/COUNT/HIT machine and flags once its input has been high on RUN_LEN
// consecutive enabled edges. Output is a level (held while in HIT) or a
// single-cycle pulse on HIT entry, selected by PULSE_MODE.
// Optional feature macro: RUN_DET_STICKY_EN adds per-channel sticky hit
// flags with a clr input.
module run_len_detector #(
  parameter  int CHANNELS   = 2,
  parameter  int RUN_LEN    = 2,
  parameter  bit PULSE_MODE = 1'b0,
  localparam int CNT_W      = $clog2(RUN_LEN + 1)
) (
  input  logic      clk,
  input  logic      reset,
  run_len_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HIT   = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RUN_LEN);
  // Where a single high sample lands from IDLE.
  localparam state_e FIRST_STATE = (RUN_LEN == 1) ? ST_HIT : ST_COUNT;

  state_e              state_q [CHANNELS];
  state_e              state_d [CHANNELS];
  logic [CNT_W-1:0]    cnt_q   [CHANNELS];
  logic [CNT_W-1:0]    cnt_d   [CHANNELS];
  logic [CHANNELS-1:0] enter_hit;
  logic [CHANNELS-1:0] out_q;
  logic [CHANNELS-1:0] out_d;
  logic [CHANNELS*CNT_W-1:0] run_cnt_flat;

  // Per-channel next state and counter; state only advances on enabled
  // edges, but an illegal encoding falls back to IDLE unconditionally.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned; that is what keeps this block latch-free.
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      enter_hit[i] = 1'b0;

      case (state_q[i])
        ST_IDLE: begin
          if (bus.en) begin
            if (bus.w[i]) begin
              state_d[i] = FIRST_STATE;
              cnt_d[i]   = CNT_ONE;
            end else begin
              cnt_d[i]   = CNT_ZERO;
            end
          end
        end

        ST_COUNT: begin
          if (bus.en) begin
            if (!bus.w[i]) begin
              state_d[i] = ST_IDLE;
              cnt_d[i]   = CNT_ZERO;
            end else if ((cnt_q[i] + CNT_ONE) == CNT_FULL) begin
              state_d[i] = ST_HIT;
              cnt_d[i]   = CNT_FULL;
            end else begin
              cnt_d[i]   = cnt_q[i] + CNT_ONE;
            end
          end
        end

        ST_HIT: begin
          if (bus.en) begin
            if (bus.w[i]) begin
              // Saturate; a held button never wraps the counter.
              cnt_d[i]   = CNT_FULL;
            end else begin
              // No grace state: a new hit needs a full fresh run.
              state_d[i] = ST_IDLE;
              cnt_d[i]   = CNT_ZERO;
            end
          end
        end

        default: begin
          state_d[i] = ST_IDLE;
          cnt_d[i]   = CNT_ZERO;
        end
      endcase

      enter_hit[i] = bus.en && (state_q[i] != ST_HIT) && (state_d[i] == ST_HIT);
    end
  end

  // Output select: level tracks the HIT state, pulse marks only the entry
  // edge (and is therefore 0 whenever en is low).
  always_comb begin
    out_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      out_d[i] = PULSE_MODE ? enter_hit[i] : (state_d[i] == ST_HIT);
    end
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the per-channel arrays are ordinary flops, not RAM, so they
      // are all reset here; nothing from an interrupted run survives.
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= CNT_ZERO;
      end
      out_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      out_q <= out_d;
    end
  end

  // Flatten the counters, channel i at [i*CNT_W +: CNT_W].
  always_comb begin
    run_cnt_flat = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      run_cnt_flat[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  assign bus.out     = out_q;
  assign bus.run_cnt = run_cnt_flat;
  assign bus.any_out = |out_q;

`ifdef RUN_DET_STICKY_EN
  logic [CHANNELS-1:0] sticky_q;
  logic [CHANNELS-1:0] sticky_d;

  // Sticky flags: a HIT entry sets, clr clears (independent of en), and a
  // set on the same edge as clr wins.
  always_comb begin
    sticky_d = sticky_q;
    if (bus.clr) begin
      sticky_d = '0;
    end
    sticky_d = sticky_d | enter_hit;
  end

  // Sticky register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign bus.sticky = sticky_q;
`endif

endmodule

// File: doc/run_len_detector.md
Name: run_len_detector

Overview:
Multi-channel consecutive-high detector. Each channel asserts its output once its input has been sampled high on RUN_LEN consecutive enabled clock edges. Generalises the fixed two-cycle, one-channel A/B/C detector with these additions:
- parametrised run length and channel count
- level or single-pulse output mode
- a global sample enable
- a per-channel saturating run counter

It sits between the synchronised player-button inputs and the game/score logic.

Parameters:
CHANNELS, 2, number of independent input/output channels (>=1)
RUN_LEN, 2, consecutive enabled edges with w=1 needed to reach HIT (>=1)
PULSE_MODE, 0, 0 = out held high while in HIT; 1 = out high for one cycle on HIT entry
CNT_W, $clog2(RUN_LEN+1), derived width of each run counter; not to be overridden

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
en  input  1  global sample enable; when low all channel state holds
w  input  CHANNELS  per-channel input, already synchronised to clk
out  output  CHANNELS  per-channel detect output, registered
run_cnt  output  CHANNELS*CNT_W  per-channel consecutive-high count, channel i in bits [i*CNT_W +: CNT_W]
any_out  output  1  OR of all out bits, combinational from registered out

Behaviour:
- Reset: reset=1 at a rising edge puts every channel in IDLE, with run_cnt=0 and out=0. Therefore any_out=0. Reset overrides en and w, and applies mid-run with no partial state kept.
- Each channel runs an independent FSM with states IDLE, COUNT and HIT, plus a counter cnt.
- State and counter update only on edges where en=1. When en=0, state and cnt hold. Level-mode out holds; pulse-mode out is 0.
- IDLE:
  - w=1 and RUN_LEN=1: go to HIT, cnt=1.
  - w=1 and RUN_LEN>1: go to COUNT, cnt=1.
  - w=0: stay in IDLE, cnt=0.
- COUNT:
  - w=0: go to IDLE, cnt=0.
  - w=1 and cnt+1==RUN_LEN: go to HIT, cnt=RUN_LEN.
  - otherwise: stay in COUNT, cnt=cnt+1.
- HIT:
  - w=1: stay in HIT, cnt saturates at RUN_LEN with no wrap.
  - w=0: go to IDLE, cnt=0. There is no intermediate state; re-triggering needs a fresh run of RUN_LEN.
- Illegal or unreachable state encodings recover to IDLE on the next edge.
- Level mode (PULSE_MODE=0):
  - out is 1 exactly while the state is HIT.
  - out first rises on the clock after the RUN_LEN-th consecutive enabled edge with w=1 has been captured. For RUN_LEN=2 this is the second such edge, the same latency as the original detector.
- Pulse mode (PULSE_MODE=1):
  - out is registered and equals 1 for one cycle after an enabled edge on which the channel enters HIT from IDLE or COUNT.
  - At most one pulse per run; holding w=1 gives no further pulses.
- Channel independence: simultaneous events on different channels are handled independently with no arbitration. any_out may have several contributing bits.
- run_cnt reflects the registered cnt, range 0..RUN_LEN.

Optional Feature:
Macro: RUN_DET_STICKY_EN.
- When defined, the block adds:
  - input clr, 1 bit
  - output sticky, CHANNELS bits
- sticky[i] behaviour:
  - Sets on any enabled edge where channel i enters HIT.
  - Clears on an edge with clr=1, regardless of en.
  - If set and clr occur on the same edge, set wins.
  - reset clears all sticky bits.
- When not defined, neither port nor any sticky logic exists, and behaviour is exactly as above.

Test Plan:
1. RUN_LEN=3, level mode, ch0: reset, then w0=1 for 5 edges -> run_cnt0 goes 1,2,3,3,3; out0=0 after edges 1-2 and out0=1 after edges 3-5. Then w0=0 -> out0=0 and run_cnt0=0 after the next edge.
2. RUN_LEN=3, ch0: w0 pattern 1,1,0,1,1,1 -> out0 never high before the 6th edge; rises after the 6th edge. run_cnt0 sequence is 1,2,0,1,2,3.
3. RUN_LEN=3, PULSE_MODE=1: w0=1 for 6 edges -> out0=1 only in the cycle after edge 3. Then w0 low one edge, high for 3 more edges -> exactly one more pulse.
4. en gating: run_cnt0=2 with en=0 for 4 edges while w0 toggles -> run_cnt0 stays 2. Then en=1 and w0=1 -> HIT after one edge.
5. Reset mid-HIT on ch0 and ch1 together with w=1 -> out=0, run_cnt=0, any_out=0 after the reset edge. Release reset with w held at 1 -> HIT again after RUN_LEN edges.
6. RUN_DET_STICKY_EN: ch1 reaches HIT on the same edge as clr=1 -> sticky1=1. clr=1 on the next edge with w1=0 -> sticky1=0.
